// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: receive-side monitor for a scanned 7-seg bus.
// Qualifies digits by stability and rebuilds 4-digit frames.
module seg7_scan_capture #(
  parameter int STABLE_CYCLES = 16,
  parameter int TIMEOUT_W     = 18
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic [3:0]  an,
  input  logic [6:0]  a_to_g,
  output logic [15:0] digits,
  output logic [3:0]  blank,
  output logic [3:0]  err,
  output logic        frame_valid,
  output logic        stale
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // registered bus copies
  logic [3:0] an_q;
  logic [6:0] seg_q;

  // tracker state
  state_t          state;
  logic [3:0]      ref_an;
  logic [6:0]      ref_seg;
  logic [CW-1:0]   cnt;

  // frame assembly
  logic [15:0]     sh_digits;
  logic [3:0]      sh_blank;
  logic [3:0]      sh_err;
  logic [3:0]      seen;
  logic [TIMEOUT_W-1:0] timer;

  // combinational helpers
  logic            strobe_ok;
  logic            same;
  logic            capture;
  logic            frame_now;
  logic [1:0]      slot;
  logic [3:0]      slot_oh;
  logic [3:0]      dec_val;
  logic            dec_blank;
  logic            dec_err;
  logic [3:0]      cap_mask;
  logic [TIMEOUT_W-1:0] timer_nx;

  // register the raw bus once before any decision
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      an_q  <= 4'b0000;
      seg_q <= 7'b0000000;
    end else begin
      an_q  <= an;
      seg_q <= a_to_g;
    end
  end

  // strobe qualification and slot select
  always_comb begin
    strobe_ok = 1'b0;
    slot      = 2'd0;
    unique case (an_q)
      4'b1110: begin strobe_ok = 1'b1; slot = 2'd0; end
      4'b1101: begin strobe_ok = 1'b1; slot = 2'd1; end
      4'b1011: begin strobe_ok = 1'b1; slot = 2'd2; end
      4'b0111: begin strobe_ok = 1'b1; slot = 2'd3; end
      default: begin strobe_ok = 1'b0; slot = 2'd0; end
    endcase
    slot_oh = strobe_ok ? ~an_q : 4'b0000;
  end

  // active-low segment pattern back to a hex value
  always_comb begin
    dec_val   = 4'h0;
    dec_blank = 1'b0;
    dec_err   = 1'b0;
    case (seg_q)
      7'b0000001: dec_val = 4'h0;
      7'b1001111: dec_val = 4'h1;
      7'b0010010: dec_val = 4'h2;
      7'b0000110: dec_val = 4'h3;
      7'b1001100: dec_val = 4'h4;
      7'b0100100: dec_val = 4'h5;
      7'b0100000: dec_val = 4'h6;
      7'b0001111: dec_val = 4'h7;
      7'b0000000: dec_val = 4'h8;
      7'b0000100: dec_val = 4'h9;
      7'b0001000: dec_val = 4'hA;
      7'b1100000: dec_val = 4'hB;
      7'b0110001: dec_val = 4'hC;
      7'b1000010: dec_val = 4'hD;
      7'b0110000: dec_val = 4'hE;
      7'b0111000: dec_val = 4'hF;
      7'b1111111: dec_blank = 1'b1;
      default:    dec_err   = 1'b1;
    endcase
  end

  // capture fires on the 16th identical sample
  always_comb begin
    same      = ({an_q, seg_q} == {ref_an, ref_seg});
    capture   = (state == TRACK) && strobe_ok &&
                same && (cnt == CNT_LAST);
    frame_now = (seen == 4'b1111);
    cap_mask  = capture ? slot_oh : 4'b0000;
    if (frame_now) begin
      timer_nx = '0;
    end else if (&timer) begin
      timer_nx = timer;
    end else begin
      timer_nx = timer + 1'b1;
    end
  end

  // stability tracker FSM
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state   <= IDLE;
      ref_an  <= 4'b0000;
      ref_seg <= 7'b0000000;
      cnt     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (strobe_ok) begin
            state   <= TRACK;
            ref_an  <= an_q;
            ref_seg <= seg_q;
            cnt     <= CNT_ONE;
          end
        end
        TRACK: begin
          if (!strobe_ok) begin
            state <= IDLE;
          end else if (!same) begin
            ref_an  <= an_q;
            ref_seg <= seg_q;
            cnt     <= CNT_ONE;
          end else if (cnt == CNT_LAST) begin
            state <= HOLD;
            cnt   <= cnt + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (!strobe_ok) begin
            state <= IDLE;
          end else if (!same) begin
            state   <= TRACK;
            ref_an  <= an_q;
            ref_seg <= seg_q;
            cnt     <= CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // shadow slots and seen mask
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      sh_digits <= 16'h0000;
      sh_blank  <= 4'b0000;
      sh_err    <= 4'b0000;
      seen      <= 4'b0000;
    end else begin
      if (capture) begin
        sh_digits[{slot, 2'b00} +: 4] <= dec_val;
        sh_blank[slot] <= dec_blank;
        sh_err[slot]   <= dec_err;
      end
      if (frame_now) begin
        seen <= cap_mask;
      end else begin
        seen <= seen | cap_mask;
      end
    end
  end

  // frame publish and stale timer
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      digits      <= 16'h0000;
      blank       <= 4'b0000;
      err         <= 4'b0000;
      frame_valid <= 1'b0;
      timer       <= '0;
      stale       <= 1'b0;
    end else begin
      frame_valid <= frame_now;
      if (frame_now) begin
        digits <= sh_digits;
        blank  <= sh_blank;
        err    <= sh_err;
      end
      timer <= timer_nx;
      stale <= &timer_nx;
    end
  end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb_seg7_scan_capture: directed checks of the 7-seg
// scan capture monitor with hand-computed frames.
module tb_seg7_scan_capture;

  localparam logic [6:0] P0 = 7'b0000001;
  localparam logic [6:0] P1 = 7'b1001111;
  localparam logic [6:0] P2 = 7'b0010010;
  localparam logic [6:0] P3 = 7'b0000110;
  localparam logic [6:0] P4 = 7'b1001100;
  localparam logic [6:0] P5 = 7'b0100100;
  localparam logic [6:0] P6 = 7'b0100000;
  localparam logic [6:0] P7 = 7'b0001111;
  localparam logic [6:0] P8 = 7'b0000000;
  localparam logic [6:0] P9 = 7'b0000100;
  localparam logic [6:0] PB = 7'b1100000;
  localparam logic [6:0] PE = 7'b0110000;
  localparam logic [6:0] PF = 7'b0111000;
  localparam logic [6:0] PX = 7'b1111111;
  localparam logic [6:0] PBAD = 7'b1010101;

  localparam logic [3:0] S0 = 4'b1110;
  localparam logic [3:0] S1 = 4'b1101;
  localparam logic [3:0] S2 = 4'b1011;
  localparam logic [3:0] S3 = 4'b0111;
  localparam logic [3:0] NONE = 4'b1111;

  logic        clk;
  logic        clr_n;
  logic [3:0]  an;
  logic [6:0]  a_to_g;
  logic [15:0] digits;
  logic [3:0]  blank;
  logic [3:0]  err;
  logic        frame_valid;
  logic        stale;

  int n_chk;
  int n_fail;
  int fv_cnt;
  int btb_cnt;
  logic fv_prev;

  seg7_scan_capture #(
    .STABLE_CYCLES(16),
    .TIMEOUT_W(8)
  ) dut (
    .clk(clk),
    .clr_n(clr_n),
    .an(an),
    .a_to_g(a_to_g),
    .digits(digits),
    .blank(blank),
    .err(err),
    .frame_valid(frame_valid),
    .stale(stale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pulse counter, sampled away from the active edge
  always @(negedge clk) begin
    if (frame_valid) fv_cnt++;
    if (frame_valid && fv_prev) btb_cnt++;
    fv_prev = frame_valid;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] a,
                       input logic [6:0] s,
                       input int n);
    an     = a;
    a_to_g = s;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    fv_cnt  = 0;
    btb_cnt = 0;
    fv_prev = 1'b0;
    clr_n   = 1'b0;
    an      = NONE;
    a_to_g  = PX;
    repeat (3) @(negedge clk);
    chk("rst_digits", 32'(digits), 32'h0);
    chk("rst_blank", 32'(blank), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_fv", 32'(frame_valid), 32'h0);
    chk("rst_stale", 32'(stale), 32'h0);
    clr_n = 1'b1;

    // basic 1,0,1,0 scan
    drive(S0, P1, 20);
    drive(S1, P0, 20);
    drive(S2, P1, 20);
    drive(S3, P0, 20);
    drive(NONE, PX, 5);
    chk("t1_fv", 32'(fv_cnt), 32'd1);
    chk("t1_digits", 32'(digits), 32'h0101);
    chk("t1_blank", 32'(blank), 32'h0);
    chk("t1_err", 32'(err), 32'h0);
    chk("t1_stale", 32'(stale), 32'h0);

    // strobes too short to qualify
    drive(S0, P8, 10);
    drive(S1, P8, 10);
    drive(S2, P8, 10);
    drive(S3, P8, 10);
    drive(NONE, PX, 5);
    chk("t3_fv", 32'(fv_cnt), 32'd1);
    chk("t3_digits", 32'(digits), 32'h0101);

    // all anodes on is not a valid strobe
    drive(4'b0000, P0, 100);
    drive(NONE, PX, 5);
    chk("t4_fv", 32'(fv_cnt), 32'd1);
    chk("t4_digits", 32'(digits), 32'h0101);

    // bad pattern on slot2, blank on slot3
    drive(S0, PF, 20);
    drive(S1, PB, 20);
    drive(S2, PBAD, 20);
    drive(S3, PX, 20);
    drive(NONE, PX, 5);
    chk("t5_fv", 32'(fv_cnt), 32'd2);
    chk("t5_digits", 32'(digits), 32'h00BF);
    chk("t5_blank", 32'(blank), 32'b1000);
    chk("t5_err", 32'(err), 32'b0100);
    chk("t5_stale", 32'(stale), 32'h0);

    // 15 samples is one short of acceptance
    drive(S0, P1, 15);
    drive(S1, P2, 15);
    drive(S2, P3, 15);
    drive(S3, P4, 15);
    drive(NONE, PX, 5);
    chk("b15_fv", 32'(fv_cnt), 32'd2);

    // exactly 16 samples is accepted
    drive(S0, P4, 16);
    drive(S1, P3, 16);
    drive(S2, P2, 16);
    drive(S3, P1, 16);
    drive(NONE, PX, 5);
    chk("b16_fv", 32'(fv_cnt), 32'd3);
    chk("b16_digits", 32'(digits), 32'h1234);

    // hold one slot forever: no frame, then stale
    drive(S0, PE, 100);
    chk("t2_fv_mid", 32'(fv_cnt), 32'd3);
    chk("t2_stale_mid", 32'(stale), 32'h0);
    drive(S0, PE, 200);
    chk("t2_fv", 32'(fv_cnt), 32'd3);
    chk("t2_stale", 32'(stale), 32'h1);
    drive(S1, P1, 20);
    drive(S2, P2, 20);
    drive(S3, P3, 20);
    drive(NONE, PX, 5);
    chk("t2_fv_end", 32'(fv_cnt), 32'd4);
    chk("t2_digits", 32'(digits), 32'h321E);
    chk("t2_unstale", 32'(stale), 32'h0);

    // reset mid-frame discards partial progress
    drive(S0, P5, 20);
    drive(S1, P6, 20);
    drive(S2, P7, 20);
    an     = NONE;
    a_to_g = PX;
    clr_n  = 1'b0;
    @(negedge clk);
    clr_n  = 1'b1;
    chk("t6_rst_digits", 32'(digits), 32'h0);
    drive(S3, P9, 20);
    drive(NONE, PX, 5);
    chk("t6_fv_s3", 32'(fv_cnt), 32'd4);
    drive(S0, P5, 20);
    drive(S1, P6, 20);
    chk("t6_fv_s1", 32'(fv_cnt), 32'd4);
    drive(S2, P7, 20);
    drive(NONE, PX, 5);
    chk("t6_fv", 32'(fv_cnt), 32'd5);
    chk("t6_digits", 32'(digits), 32'h9765);
    chk("t6_err", 32'(err), 32'h0);

    chk("fv_b2b", 32'(btb_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
